// File: rtl/seq_det_sched_pkg.sv
// Shared definitions for the serialising detector scheduler: FSM state encoding
// and the number of requesters.
package seq_det_sched_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/seq_det_sched_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant when enabled, with a
// pointer that favours the requester not granted last.
module rr_arb2
  import seq_det_sched_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               gnt_en_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  // ptr_q names the requester that wins a tie
  logic ptr_q;

  always_comb begin
    gnt_o = '0;
    if (gnt_en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else if (gnt_en_i && (|req_i)) begin
      ptr_q <= gnt_o[0];
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Arbitrates two requesters, serialises the winning word MSB-first to an external
// detector, counts the detector's registered match flags and holds the result until acked.
module seq_det_sched
  import seq_det_sched_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [WORD_W-1:0]  i_word0,
  input  logic [WORD_W-1:0]  i_word1,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_det_clr,
  output logic               o_det_valid,
  output logic               o_det_data,
  input  logic               i_det_en,
  output logic               o_done,
  output logic               o_done_id,
  output logic [CNT_W-1:0]   o_hits,
  input  logic               i_ack
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e               state_q;
  logic [WORD_W-1:0]    sr_q;
  logic [IDX_W-1:0]     idx_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 vld_d1_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic                 clr_q;
  logic                 vld_q;
  logic                 data_q;
  logic                 done_q;
  logic                 done_id_q;
  logic                 cur_id_q;
  logic [NUM_REQ-1:0]   arb_gnt;

  rr_arb2 u_arb (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .req_i    (i_req),
    .gnt_en_i (state_q == IDLE),
    .gnt_o    (arb_gnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      vld_d1_q  <= 1'b0;
      gnt_q     <= '0;
      clr_q     <= 1'b0;
      vld_q     <= 1'b0;
      data_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      cur_id_q  <= 1'b0;
    end else begin
      gnt_q    <= '0;
      clr_q    <= 1'b0;
      // The detector answers one cycle after each bit, so the delayed valid is the count window
      vld_d1_q <= vld_q;
      if (vld_d1_q && i_det_en) begin
        cnt_q <= sat_inc(cnt_q);
      end
      case (state_q)
        IDLE: begin
          if (|arb_gnt) begin
            gnt_q    <= arb_gnt;
            clr_q    <= 1'b1;
            cur_id_q <= arb_gnt[1];
            sr_q     <= arb_gnt[1] ? i_word1 : i_word0;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          cnt_q   <= '0;
          vld_q   <= 1'b1;
          data_q  <= sr_q[WORD_W-1];
          sr_q    <= sr_q << 1;
          idx_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (idx_q == LAST_IDX) begin
            vld_q   <= 1'b0;
            data_q  <= 1'b0;
            state_q <= DRAIN;
          end else begin
            data_q <= sr_q[WORD_W-1];
            sr_q   <= sr_q << 1;
            idx_q  <= idx_q + IDX_W'(1);
          end
        end
        DRAIN: begin
          done_q    <= 1'b1;
          done_id_q <= cur_id_q;
          state_q   <= DONE;
        end
        DONE: begin
          if (i_ack) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_gnt       = gnt_q;
  assign o_det_clr   = clr_q;
  assign o_det_valid = vld_q;
  assign o_det_data  = data_q;
  assign o_done      = done_q;
  assign o_done_id   = done_id_q;
  assign o_hits      = cnt_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Randomised scoreboard bench for seq_det_sched with a cycle-timed behavioural model.
module tb_seq_det_sched;

  localparam int WORD_W = 8;
  localparam int CNT_W  = 4;
  localparam int CNT2_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        i_req = 2'b00;
  logic [WORD_W-1:0] w0 = '0;
  logic [WORD_W-1:0] w1 = '0;
  logic              det_en = 1'b0;
  logic              ack = 1'b0;

  logic [1:0]        gnt, gnt2;
  logic              clr, vld, dat, done, done_id;
  logic              clr2, vld2, dat2, done2, done_id2;
  logic [CNT_W-1:0]  hits;
  logic [CNT2_W-1:0] hits2;

  seq_det_sched #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_word0(w0), .i_word1(w1),
    .o_gnt(gnt), .o_det_clr(clr), .o_det_valid(vld), .o_det_data(dat),
    .i_det_en(det_en), .o_done(done), .o_done_id(done_id), .o_hits(hits), .i_ack(ack)
  );

  seq_det_sched #(.WORD_W(WORD_W), .CNT_W(CNT2_W)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_word0(w0), .i_word1(w1),
    .o_gnt(gnt2), .o_det_clr(clr2), .o_det_valid(vld2), .o_det_data(dat2),
    .i_det_en(det_en), .o_done(done2), .o_done_id(done_id2), .o_hits(hits2), .i_ack(ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] gnt;
    logic       clr, vld, dat, done, id;
    int         hits, hits2;
  } cyc_exp_t;

  typedef struct {
    logic id;
    int   hits, hits2;
  } res_t;

  cyc_exp_t exp_q[$];
  res_t     res_q[$];
  int total = 0;
  int bad = 0;

  // model state
  bit              m_busy = 1'b0;
  bit              m_last = 1'b1;
  int              m_N = 0;
  int              m_free_at = 0;
  int              m_grants = 0;
  int              m_hits = 0, m_hits2 = 0;
  logic [WORD_W-1:0] m_word = '0, m_mask = '0;
  int              drop_at = -1;
  int              drop_id = 0;

  // knobs
  bit              ack_hold = 1'b0;
  int              ack_dly = 1;
  int              junk_mode = 2;
  bit              mask_force = 1'b0;
  logic [WORD_W-1:0] mask_val = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at cycle %0d", nm, act, want, cyc);
    end
  endtask

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  // One model step at the negedge of cycle c: choose the inputs sampled at the end of c and
  // predict the outputs of cycle c+1 from the request-to-result timeline.
  task automatic step();
    int c, t, win, pop;
    bit done_c, granted;
    cyc_exp_t e;
    res_t r;
    c = cyc;
    granted = 1'b0;
    win = 0;
    if (drop_at == c) i_req[drop_id] = 1'b0;
    done_c = m_busy && (c >= m_N + WORD_W + 3);
    if (ack_hold) ack = 1'b1;
    else if (done_c) ack = (c >= m_N + WORD_W + 3 + ack_dly);
    else ack = 1'($urandom_range(0, 1));
    if (done_c && ack) begin
      m_busy = 1'b0;
      m_free_at = c + 1;
    end
    if (m_busy && c >= m_N + 3 && c <= m_N + WORD_W + 2) det_en = m_mask[c - m_N - 3];
    else if (junk_mode == 2) det_en = 1'($urandom_range(0, 1));
    else det_en = junk_mode[0];
    if (!m_busy && c >= m_free_at && i_req != 2'b00) begin
      win = (i_req == 2'b11) ? int'(!m_last) : int'(i_req[1]);
      m_word = win ? w1 : w0;
      m_mask = mask_force ? mask_val : WORD_W'($urandom);
      pop = $countones(m_mask);
      m_hits = sat(pop, CNT_W);
      m_hits2 = sat(pop, CNT2_W);
      r.id = win[0]; r.hits = m_hits; r.hits2 = m_hits2;
      res_q.push_back(r);
      m_busy = 1'b1; m_N = c; m_last = win[0]; m_grants++;
      drop_at = c + 1; drop_id = win;
      granted = 1'b1;
    end
    t = c + 1 - m_N;
    e.cyc   = c + 1;
    e.gnt   = granted ? (win ? 2'b10 : 2'b01) : 2'b00;
    e.clr   = granted;
    e.vld   = m_busy && t >= 2 && t <= WORD_W + 1;
    e.dat   = e.vld ? m_word[WORD_W - 1 - (t - 2)] : 1'b0;
    e.done  = m_busy && t >= WORD_W + 3;
    e.id    = m_last;
    e.hits  = m_hits;
    e.hits2 = m_hits2;
    exp_q.push_back(e);
  endtask

  task automatic run_until_idle(input int maxc);
    for (int k = 0; k < maxc; k++) begin
      if (!m_busy && i_req == 2'b00) break;
      @(negedge clk);
      step();
    end
    chk("drain_bound", {31'd0, m_busy}, 32'd0);
  endtask

  task automatic issue(input logic [1:0] req, input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
    @(negedge clk);
    w0 = a; w1 = b; i_req = req;
    step();
    run_until_idle(300);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_clr"}, clr, 0);
    chk({tag, "_vld"}, vld, 0);
    chk({tag, "_dat"}, dat, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_id"}, done_id, 0);
    chk({tag, "_hits"}, hits, 0);
    chk({tag, "_hits2"}, hits2, 0);
  endtask

  // monitor: per-cycle expectations plus the result scoreboard on each new o_done
  initial begin
    cyc_exp_t e;
    res_t r;
    bit prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_done = 1'b0;
        continue;
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("gnt", gnt, e.gnt);
        chk("clr", clr, e.clr);
        chk("vld", vld, e.vld);
        if (e.vld) chk("bit", dat, e.dat);
        chk("done", done, e.done);
        chk("done_sat", done2, e.done);
        if (e.done) begin
          chk("hold_id", done_id, e.id);
          chk("hold_hits", hits, e.hits);
        end
      end
      if (done && !prev_done) begin
        if (res_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          r = res_q.pop_front();
          chk("res_id", done_id, r.id);
          chk("res_hits", hits, r.hits);
          chk("res_hits_sat", hits2, r.hits2);
        end
      end
      prev_done = done;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #2 rst_n = 1'b1;

    // contention from reset: both held high, grants must alternate starting with 0
    ack_dly = 2;
    for (int k = 0; k < 200 && m_grants < 4; k++) begin
      @(negedge clk);
      if (!i_req[0]) begin w0 = WORD_W'($urandom); i_req[0] = 1'b1; end
      if (!i_req[1]) begin w1 = WORD_W'($urandom); i_req[1] = 1'b1; end
      step();
    end
    chk("contention_grants", m_grants, 4);
    run_until_idle(300);

    // single request 0xDA, detector hits for bits 2 and 5
    mask_force = 1'b1; mask_val = 8'h24;
    issue(2'b01, 8'hDA, 8'h00);

    // saturation: det_en high throughout
    mask_val = 8'hFF; junk_mode = 1;
    issue(2'b10, 8'h00, WORD_W'($urandom));

    // ack held high before DONE
    mask_force = 1'b0; junk_mode = 2; ack_hold = 1'b1;
    issue(2'b01, WORD_W'($urandom), 8'h00);
    ack_hold = 1'b0;

    // ack delayed 5 cycles with the other requester waiting
    ack_dly = 5;
    issue(2'b11, WORD_W'($urandom), WORD_W'($urandom));

    // out-of-window det_en only
    mask_force = 1'b1; mask_val = 8'h00; junk_mode = 1;
    issue(2'b01, 8'h00, 8'h00);
    mask_force = 1'b0; junk_mode = 2;

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      ack_dly = $urandom_range(0, 4);
      if (!i_req[0] && $urandom_range(0, 7) == 0) begin w0 = WORD_W'($urandom); i_req[0] = 1'b1; end
      if (!i_req[1] && $urandom_range(0, 7) == 0) begin w1 = WORD_W'($urandom); i_req[1] = 1'b1; end
      step();
    end
    run_until_idle(300);

    // reset during bit 4 of SHIFT
    ack_dly = 1;
    @(negedge clk);
    w0 = 8'hFF; i_req = 2'b01;
    step();
    for (int k = 0; k < 50; k++) begin
      if (m_busy && cyc == m_N + 6) break;
      @(negedge clk);
      step();
    end
    chk("pre_rst_vld", vld, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    exp_q.delete(); res_q.delete();
    m_busy = 1'b0; m_last = 1'b1; m_free_at = 0; drop_at = -1; i_req = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_no_done", done, 0);
    #2 rst_n = 1'b1;
    issue(2'b10, 8'h00, WORD_W'($urandom));

    repeat (3) @(negedge clk);
    chk("res_q_empty", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_det_sched.md
SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 The block SHALL have parameter WORD_W, default 8, meaning bits per word serialized into the detector.
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning hit-counter width.
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_req  input  2  per-requester request, held high until the matching o_gnt bit is seen.
REQ-006 i_word0 / i_word1  input  WORD_W each  word from requester 0 / 1, stable while its i_req is high.
REQ-007 o_gnt  output  2  one-hot, one-cycle grant pulse; the word is captured on the edge that asserts it.
REQ-008 o_det_clr  output  1  one-cycle pulse that flushes the external detector's history.
REQ-009 o_det_valid  output  1  serial bit valid to the detector.
REQ-010 o_det_data  output  1  serial bit, MSB first.
REQ-011 i_det_en  input  1  detector match flag, registered, one cycle after its bit.
REQ-012 o_done  output  1  result valid, held until acknowledged.
REQ-013 o_done_id  output  1  requester index of the result.
REQ-014 o_hits  output  CNT_W  match count for the word.
REQ-015 i_ack  input  1  result acknowledge.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, SHIFT, DRAIN and DONE, all outputs registered.
REQ-017 IDLE: on any i_req bit high, the arbiter picks the winner, the word is captured, o_gnt is pulsed, and the FSM goes to LOAD; with no request it stays in IDLE.
REQ-018 Arbitration SHALL be round-robin: a single request wins outright; when both request, the requester not granted last wins; the priority pointer updates only on a grant.
REQ-019 LOAD (1 cycle): o_gnt=one-hot winner and o_det_clr=1; the hit counter is cleared; next state is SHIFT.
REQ-020 SHIFT (WORD_W cycles): o_det_valid=1 and o_det_data=current MSB; the shift register shifts left each cycle; a bit index runs 0..WORD_W-1; after the last bit the FSM goes to DRAIN.
REQ-021 DRAIN (1 cycle): o_det_valid=0; the FSM collects the final i_det_en; next state is DONE.
REQ-022 Hit counting: a one-cycle-delayed copy of o_det_valid gates i_det_en; each gated high cycle adds 1, saturating at 2^CNT_W-1 without wrap.
REQ-023 i_det_en outside the gated window (IDLE, LOAD, DONE) SHALL be ignored.
REQ-024 DONE: o_done=1 and o_done_id/o_hits stay stable; i_ack high in any DONE cycle, including the first, returns the FSM to IDLE on that edge, with o_done low the next cycle.
REQ-025 i_ack outside DONE SHALL be ignored.
REQ-026 Requests arriving while busy SHALL be held off, with no o_gnt, until IDLE.
REQ-027 Latency: request seen in IDLE cycle N -> o_gnt/o_det_clr in cycle N+1 -> bits in N+2..N+WORD_W+1 -> DRAIN N+WORD_W+2 -> o_done from N+WORD_W+3 (N+11 for WORD_W=8).
REQ-028 Back-to-back: the earliest next grant SHALL come 1 cycle after the DONE exit, at IDLE plus 1.

Reset
REQ-029 Assertion of i_rst_n low SHALL, at any time including mid-SHIFT, immediately force IDLE, priority to requester 0, and o_gnt=0, o_det_clr=0, o_det_valid=0, o_det_data=0, o_done=0, o_done_id=0, o_hits=0, shift register and counters 0.
REQ-030 After reset deasserts, the first grant SHALL follow REQ-017 timing.
REQ-031 An aborted word SHALL produce no o_done.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, with IDLE=0, and the requester-count constant (2).
REQ-033 The round-robin arbiter SHALL be one sub-module, rr_arb2 (req[1:0], grant enable, one-hot grant, pointer register); all other logic is inline.

Verification
REQ-034 Single request: i_req=01 with i_word0=8'hDA, bench i_det_en high in cycles N+5 and N+8 -> o_gnt=01 at N+1, o_det_data sequence 1,1,0,1,1,0,1,0 in N+2..N+9, o_done at N+11, o_hits=2, o_done_id=0.
REQ-035 Contention: i_req=11 held from reset, with acks -> grants alternate 01,10,01,10 and o_done_id alternates 0,1,0,1.
REQ-036 Saturation: CNT_W=2, i_det_en held high throughout -> o_hits=3, with no wrap to 0.
REQ-037 Ack timing: i_ack held high before DONE -> o_done high exactly 1 cycle; i_ack delayed 5 cycles -> o_done and o_hits stable for 5 cycles, with no new o_gnt meanwhile.
REQ-038 Reset mid-operation: reset asserted at bit 4 of SHIFT -> all outputs 0 asynchronously, no o_done, and after release i_req=10 -> o_gnt=10.
REQ-039 Out-of-window ignore: i_det_en pulsed in IDLE and in LOAD cycles -> o_hits=0 for word 8'h00.
